aes_key_expand: RTL

- Key-expansion and round-key store for the AES datapath.
- Sits directly upstream of the decipher core: it expands a 128- or 256-bit cipher key into 11 or 15 round keys, one per clock.
- It stores them, then serves `round_key` combinationally for the round index the core drives on `round`.
- `ready` tells the system controller that the schedule is complete and decryption may be started.

---
 rtl/aes_key_expand.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// AES key expansion and round-key store.
// Expands a 128-bit or 256-bit cipher key into 11 or 15 round keys, one per clock,
// and stores them. It then serves the round key for the requested index combinationally.
module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready
);

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;
  localparam int         NUM_KEYS      = 15;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GEN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Forward S-box. Entry 0 sits at the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX_TABLE[idx*8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   state_q,  state_d;
  logic         keylen_q, keylen_d;
  logic [255:0] key_q,    key_d;
  logic [7:0]   rcon_q,   rcon_d;
  logic [3:0]   cnt_q,    cnt_d;
  logic [127:0] prev_q,   prev_d;
  logic [127:0] prev2_q,  prev2_d;
  logic         ready_q,  ready_d;
  logic [127:0] mem_q [NUM_KEYS];
  logic [127:0] mem_d [NUM_KEYS];

  logic [3:0]   last_round;
  logic         use_rot;
  logic [31:0]  t_word;
  logic [127:0] base_key;
  logic [127:0] new_key;

  // Next round key from prev/prev2. Odd AES-256 steps skip RotWord and rcon.
  always_comb begin
    last_round = keylen_q ? AES256_ROUNDS : AES128_ROUNDS;
    use_rot    = !keylen_q || !cnt_q[0];
    base_key   = keylen_q ? prev2_q : prev_q;
    if (use_rot) begin
      t_word = sub_word(rot_word(prev_q[31:0])) ^ {rcon_q, 24'h0};
    end else begin
      t_word = sub_word(prev_q[31:0]);
    end
    new_key[127:96] = base_key[127:96] ^ t_word;
    new_key[95:64]  = base_key[95:64]  ^ new_key[127:96];
    new_key[63:32]  = base_key[63:32]  ^ new_key[95:64];
    new_key[31:0]   = base_key[31:0]   ^ new_key[63:32];
  end

  // Control FSM and round-key memory writes. init overrides every state.
  always_comb begin
    state_d  = state_q;
    keylen_d = keylen_q;
    key_d    = key_q;
    rcon_d   = rcon_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    prev2_d  = prev2_q;
    ready_d  = ready_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (init) begin
      key_d    = key;
      keylen_d = keylen;
      rcon_d   = 8'h01;
      ready_d  = 1'b0;
      state_d  = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          mem_d[0] = key_q[255:128];
          if (keylen_q) begin
            mem_d[1] = key_q[127:0];
            prev_d   = key_q[127:0];
            prev2_d  = key_q[255:128];
            cnt_d    = 4'd2;
          end else begin
            prev_d   = key_q[255:128];
            cnt_d    = 4'd1;
          end
          state_d = S_GEN;
        end
        S_GEN: begin
          if (cnt_q <= AES256_ROUNDS) begin
            mem_d[cnt_q] = new_key;
          end
          prev2_d = prev_q;
          prev_d  = new_key;
          cnt_d   = cnt_q + 4'd1;
          if (use_rot) begin
            rcon_d = xtime(rcon_q);
          end
          if (cnt_q == last_round) begin
            ready_d = 1'b1;
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State registers and memory; reset clears everything including stored keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      keylen_q <= 1'b0;
      key_q    <= '0;
      rcon_q   <= 8'h00;
      cnt_q    <= 4'd0;
      prev_q   <= '0;
      prev2_q  <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      keylen_q <= keylen_d;
      key_q    <= key_d;
      rcon_q   <= rcon_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      prev2_q  <= prev2_d;
      ready_q  <= ready_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Zero-latency lookup; indices past the last round of the latched key length read as zero.
  always_comb begin
    round_key = '0;
    if (round <= last_round) begin
      round_key = mem_q[round];
    end
  end

  assign ready = ready_q;

endmodule
